// File: rtl/scarv_cop_issue.sv
// scarv_cop_issue: host-side issue FSM, in-flight credit counter and one-entry COP response slot.
module scarv_cop_issue #(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        g_clk,
    input  logic        g_reset,
    input  logic        host_valid,
    output logic        host_ready,
    input  logic [31:0] host_insn_enc,
    input  logic [31:0] host_rs1,
    input  logic        host_abort,
    output logic        cpu_insn_req,
    input  logic        cop_insn_ack,
    output logic        cpu_abort_req,
    output logic [31:0] cpu_insn_enc,
    output logic [31:0] cpu_rs1,
    input  logic        cop_insn_rsp,
    output logic        cpu_insn_ack,
    input  logic        cop_wen,
    input  logic [4:0]  cop_waddr,
    input  logic [31:0] cop_wdata,
    input  logic [2:0]  cop_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_wen,
    output logic [4:0]  rsp_waddr,
    output logic [31:0] rsp_wdata,
    output logic [2:0]  rsp_result,
    output logic [3:0]  outstanding,
    output logic        err_spurious
);
    typedef enum logic [1:0] {IDLE, REQ, ABORT} state_t;
    state_t      r_state;
    logic        r_req, r_abort, r_err, r_valid, r_wen;
    logic [3:0]  r_cnt;
    logic [4:0]  r_waddr;
    logic [31:0] r_enc, r_rs1, r_wdata;
    logic [2:0]  r_result;
    logic        w_inc, w_dec;
    assign host_ready    = (r_state == IDLE) && (r_cnt < 4'(MAX_OUTSTANDING));
    assign cpu_insn_ack  = !r_valid | rsp_ready;
    assign w_inc         = r_req & cop_insn_ack;
    assign w_dec         = cop_insn_rsp & cpu_insn_ack;
    assign cpu_insn_req  = r_req;
    assign cpu_abort_req = r_abort;
    assign cpu_insn_enc  = r_enc;
    assign cpu_rs1       = r_rs1;
    assign rsp_valid     = r_valid;
    assign rsp_wen       = r_valid & r_wen;
    assign rsp_waddr     = r_waddr;
    assign rsp_wdata     = r_wdata;
    assign rsp_result    = r_result;
    assign outstanding   = r_cnt;
    assign err_spurious  = r_err;
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
            r_abort <= 1'b0;
            r_enc   <= '0;
            r_rs1   <= '0;
        end else begin
            case (r_state)
                IDLE: if (host_valid && host_ready) begin
                    r_enc   <= host_insn_enc;
                    r_rs1   <= host_rs1;
                    r_req   <= 1'b1;
                    r_state <= REQ;
                end
                // an ack in the same cycle as an abort wins
                REQ: if (cop_insn_ack) begin
                    r_req   <= 1'b0;
                    r_state <= IDLE;
                end else if (host_abort) begin
                    r_req   <= 1'b0;
                    r_abort <= 1'b1;
                    r_state <= ABORT;
                end
                ABORT: begin
                    r_abort <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_inc && !w_dec)
                r_cnt <= r_cnt + 4'd1;
            else if (w_dec && !w_inc && r_cnt != 4'd0)
                r_cnt <= r_cnt - 4'd1;
            if (w_dec && r_cnt == 4'd0)
                r_err <= 1'b1;
        end
    end
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            r_valid  <= 1'b0;
            r_wen    <= 1'b0;
            r_waddr  <= '0;
            r_wdata  <= '0;
            r_result <= '0;
        end else if (w_dec) begin
            r_valid  <= 1'b1;
            r_wen    <= cop_wen;
            r_waddr  <= cop_waddr;
            r_wdata  <= cop_wdata;
            r_result <= cop_result;
        end else if (rsp_ready) begin
            r_valid  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_scarv_cop_issue.sv
// tb_scarv_cop_issue: directed scenarios with scoreboarded issue and response queues.
module tb_scarv_cop_issue;
    logic        g_clk = 1'b0, g_reset = 1'b1;
    logic        host_valid = 0, host_abort = 0, cop_insn_ack = 0, cop_insn_rsp = 0, rsp_ready = 0;
    logic [31:0] host_insn_enc = 0, host_rs1 = 0, cop_wdata = 0;
    logic        cop_wen = 0;
    logic [4:0]  cop_waddr = 0;
    logic [2:0]  cop_result = 0;
    logic        host_ready, cpu_insn_req, cpu_abort_req, cpu_insn_ack, rsp_valid, rsp_wen, err_spurious;
    logic [31:0] cpu_insn_enc, cpu_rs1, rsp_wdata;
    logic [4:0]  rsp_waddr;
    logic [2:0]  rsp_result;
    logic [3:0]  outstanding;
    int checks = 0, errors = 0;
    logic [63:0] iq[$];
    logic [63:0] rq[$];

    scarv_cop_issue #(.MAX_OUTSTANDING(2)) dut (
        .g_clk(g_clk), .g_reset(g_reset), .host_valid(host_valid), .host_ready(host_ready),
        .host_insn_enc(host_insn_enc), .host_rs1(host_rs1), .host_abort(host_abort),
        .cpu_insn_req(cpu_insn_req), .cop_insn_ack(cop_insn_ack), .cpu_abort_req(cpu_abort_req),
        .cpu_insn_enc(cpu_insn_enc), .cpu_rs1(cpu_rs1), .cop_insn_rsp(cop_insn_rsp),
        .cpu_insn_ack(cpu_insn_ack), .cop_wen(cop_wen), .cop_waddr(cop_waddr), .cop_wdata(cop_wdata),
        .cop_result(cop_result), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_wen(rsp_wen),
        .rsp_waddr(rsp_waddr), .rsp_wdata(rsp_wdata), .rsp_result(rsp_result),
        .outstanding(outstanding), .err_spurious(err_spurious)
    );

    always #5 g_clk = ~g_clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    // handshakes are judged on the negedge, where inputs and state are stable
    always @(negedge g_clk) if (!g_reset) begin
        if (cpu_insn_req && cop_insn_ack) begin
            if (iq.size() == 0) chk("issue_unexpected", 1, 0);
            else chk("issue", {cpu_insn_enc, cpu_rs1}, iq.pop_front());
        end
        if (rsp_valid && rsp_ready) begin
            if (rq.size() == 0) chk("rsp_unexpected", 1, 0);
            else chk("rsp", 64'({rsp_wen, rsp_waddr, rsp_wdata, rsp_result}), rq.pop_front());
        end
    end

    task automatic issue(input logic [31:0] enc, input logic [31:0] rs1);
        iq.push_back({enc, rs1});
        host_valid = 1; host_insn_enc = enc; host_rs1 = rs1;
        tick();
        host_valid = 0; cop_insn_ack = 1;
        tick();
        cop_insn_ack = 0;
    endtask

    task automatic drive_rsp(input logic wen, input logic [4:0] wa, input logic [31:0] wd, input logic [2:0] res);
        rq.push_back(64'({wen, wa, wd, res}));
        cop_insn_rsp = 1; cop_wen = wen; cop_waddr = wa; cop_wdata = wd; cop_result = res;
        tick();
        cop_insn_rsp = 0;
    endtask

    task automatic drain();
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(); tick();
        chk("rst_host_ready", host_ready, 1);
        chk("rst_req", cpu_insn_req, 0);
        chk("rst_abort", cpu_abort_req, 0);
        chk("rst_enc_rs1", {cpu_insn_enc, cpu_rs1}, 0);
        chk("rst_rsp", 64'({rsp_valid, rsp_wen, rsp_waddr, rsp_wdata, rsp_result}), 0);
        chk("rst_cnt_err", {outstanding, err_spurious}, 0);
        chk("rst_insn_ack", cpu_insn_ack, 1);
        g_reset = 0;
        tick();
        // single instruction, ack two cycles after acceptance
        iq.push_back({32'h0000_002B, 32'h1234_5678});
        host_valid = 1; host_insn_enc = 32'h0000_002B; host_rs1 = 32'h1234_5678;
        tick();
        host_valid = 0; host_insn_enc = 0; host_rs1 = 0;
        chk("s_req", cpu_insn_req, 1);
        chk("s_ready_low", host_ready, 0);
        chk("s_enc_rs1", {cpu_insn_enc, cpu_rs1}, {32'h0000_002B, 32'h1234_5678});
        tick();
        chk("s_req_hold", cpu_insn_req, 1);
        chk("s_enc_hold", {cpu_insn_enc, cpu_rs1}, {32'h0000_002B, 32'h1234_5678});
        cop_insn_ack = 1;
        tick();
        cop_insn_ack = 0;
        chk("s_req_drop", cpu_insn_req, 0);
        chk("s_cnt1", outstanding, 1);
        chk("s_ready_back", host_ready, 1);
        drive_rsp(1, 5'd5, 32'hDEAD_BEEF, 3'd0);
        chk("s_rsp_valid", rsp_valid, 1);
        chk("s_rsp_fields", 64'({rsp_wen, rsp_waddr, rsp_wdata, rsp_result}), 64'({1'b1, 5'd5, 32'hDEAD_BEEF, 3'd0}));
        chk("s_cnt0", outstanding, 0);
        drain();
        chk("s_slot_empty", rsp_valid, 0);
        // credit limit of two
        issue(32'hA, 32'h1);
        issue(32'hB, 32'h2);
        chk("c_cnt2", outstanding, 2);
        chk("c_ready_low", host_ready, 0);
        host_valid = 1; host_insn_enc = 32'hC;
        tick(); tick();
        chk("c_no_req", cpu_insn_req, 0);
        host_valid = 0;
        drive_rsp(0, 5'd1, 32'h11, 3'd1);
        chk("c_ready_restored", host_ready, 1);
        chk("c_cnt1", outstanding, 1);
        drain();
        drive_rsp(1, 5'd2, 32'h22, 3'd2);
        drain();
        chk("c_cnt0", outstanding, 0);
        // abort while the COP has not acked
        host_valid = 1; host_insn_enc = 32'hD; host_rs1 = 32'h3;
        tick();
        host_valid = 0; host_abort = 1;
        tick();
        host_abort = 0;
        chk("a_req_drop", cpu_insn_req, 0);
        chk("a_pulse", cpu_abort_req, 1);
        chk("a_cnt", outstanding, 0);
        tick();
        chk("a_pulse_end", cpu_abort_req, 0);
        chk("a_ready", host_ready, 1);
        // abort coinciding with ack
        iq.push_back({32'hE, 32'h4});
        host_valid = 1; host_insn_enc = 32'hE; host_rs1 = 32'h4;
        tick();
        host_valid = 0; host_abort = 1; cop_insn_ack = 1;
        tick();
        host_abort = 0; cop_insn_ack = 0;
        chk("aa_no_pulse", cpu_abort_req, 0);
        chk("aa_cnt", outstanding, 1);
        tick();
        chk("aa_no_pulse2", cpu_abort_req, 0);
        // backpressure, then simultaneous drain and capture
        drive_rsp(1, 5'd7, 32'h7777, 3'd3);
        chk("b_valid", rsp_valid, 1);
        chk("b_ack_low", cpu_insn_ack, 0);
        issue(32'hF, 32'h5);
        cop_insn_rsp = 1; cop_wen = 1; cop_waddr = 5'd9; cop_wdata = 32'h9999; cop_result = 3'd4;
        tick();
        chk("b_hold", rsp_wdata, 32'h7777);
        chk("b_cnt_hold", outstanding, 1);
        rq.push_back(64'({1'b1, 5'd9, 32'h9999, 3'd4}));
        rsp_ready = 1;
        #1;
        chk("b_ack_comb", cpu_insn_ack, 1);
        tick();
        cop_insn_rsp = 0; rsp_ready = 0;
        chk("b_new_valid", rsp_valid, 1);
        chk("b_new_data", rsp_wdata, 32'h9999);
        chk("b_cnt0", outstanding, 0);
        drain();
        chk("b_empty", rsp_valid, 0);
        // spurious response
        drive_rsp(0, 5'd3, 32'h3333, 3'd5);
        chk("sp_err", err_spurious, 1);
        chk("sp_cnt", outstanding, 0);
        drain();
        // asynchronous reset mid-request
        host_valid = 1; host_insn_enc = 32'h55; host_rs1 = 32'h66;
        tick();
        host_valid = 0;
        chk("r_req_pre", cpu_insn_req, 1);
        #2 g_reset = 1;
        #1;
        chk("r_req", cpu_insn_req, 0);
        chk("r_abort", cpu_abort_req, 0);
        chk("r_ready", host_ready, 1);
        chk("r_enc_rs1", {cpu_insn_enc, cpu_rs1}, 0);
        chk("r_err_cnt", {outstanding, err_spurious}, 0);
        chk("r_rsp", 64'({rsp_valid, rsp_wen, rsp_waddr, rsp_wdata, rsp_result}), 0);
        tick();
        g_reset = 0;
        tick();
        chk("iq_empty", iq.size(), 0);
        chk("rq_empty", rq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
